// File: rtl/volume_amp_ctrl.sv
// volume_amp_ctrl
//   Volume / mute controller driving the note generator's square-wave
//   amplitude. Button levels are edge-detected into one-cycle events, a
//   saturating volume level and a mute flag are kept, and the output
//   amplitude slews toward the target in bounded steps so that volume
//   changes do not produce audible clicks.
//
// Ports
//   i_clk         system clock
//   i_rst         synchronous reset, active high
//   i_vol_up      debounced button level, volume up
//   i_vol_down    debounced button level, volume down
//   i_mute_tgl    debounced button level, toggle mute
//   o_vol_level   current volume level, 0..VOL_MAX
//   o_muted       1 = muted (target amplitude 0)
//   o_amp_pos     signed high sample, equals the current amplitude
//   o_amp_neg     signed low sample, two's complement negation of o_amp_pos
//   o_ramp_busy   1 while the amplitude is slewing toward the target
//
// Parameters
//   VOL_MAX    highest volume level
//   VOL_INIT   volume level after reset
//   LVL_STEP   amplitude per volume level (VOL_MAX*LVL_STEP <= 32767)
//   RAMP_STEP  largest amplitude change per ramp tick
//   RAMP_DIV   clock cycles per ramp tick (>= 1)

module volume_amp_ctrl #(
  parameter int VOL_MAX   = 15,
  parameter int VOL_INIT  = 8,
  parameter int LVL_STEP  = 2000,
  parameter int RAMP_STEP = 250,
  parameter int RAMP_DIV  = 1000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_vol_up,
  input  logic        i_vol_down,
  input  logic        i_mute_tgl,
  output logic [3:0]  o_vol_level,
  output logic        o_muted,
  output logic [15:0] o_amp_pos,
  output logic [15:0] o_amp_neg,
  output logic        o_ramp_busy
);

  // A one-cycle tick still needs a 1-bit counter to keep the vector legal.
  localparam int               CNT_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAMP_DIV - 1);
  localparam logic [14:0]      STEP     = 15'(RAMP_STEP);
  localparam logic [3:0]       VMAX     = 4'(VOL_MAX);
  localparam logic [3:0]       VINIT    = 4'(VOL_INIT);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RAMP = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  // Button history. Reset to 1 so a button already held during reset has
  // to be released and pressed again before it produces an event.
  logic             r_up_prev;
  logic             r_dn_prev;
  logic             r_mt_prev;

  logic [3:0]       r_vol;
  logic             r_muted;
  logic [14:0]      r_amp;     // amplitude is never negative, 15 bits suffice
  logic [CNT_W-1:0] r_cnt;

  logic             w_up_ev;
  logic             w_dn_ev;
  logic             w_mt_ev;
  logic [3:0]       w_vol_nxt;
  logic [14:0]      w_target;
  logic             w_dir_up;
  logic [14:0]      w_diff;
  logic [14:0]      w_amp_step;
  logic             w_tick;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [14:0]      w_amp_nxt;

  // ---------------------------------------------------------------------
  // Button events: one per rising level, however long the button is held
  // ---------------------------------------------------------------------
  assign w_up_ev = i_vol_up   & ~r_up_prev;
  assign w_dn_ev = i_vol_down & ~r_dn_prev;
  assign w_mt_ev = i_mute_tgl & ~r_mt_prev;

  // ---------------------------------------------------------------------
  // Volume level: simultaneous up and down events cancel each other.
  // Mute is handled separately so both can apply in the same cycle, and
  // the level keeps moving while muted so it takes effect on unmute.
  // ---------------------------------------------------------------------
  always_comb begin
    w_vol_nxt = r_vol;
    if (w_up_ev && !w_dn_ev && (r_vol < VMAX)) begin
      w_vol_nxt = r_vol + 4'd1;
    end else if (w_dn_ev && !w_up_ev && (r_vol != 4'd0)) begin
      w_vol_nxt = r_vol - 4'd1;
    end
  end

  // ---------------------------------------------------------------------
  // Target amplitude, derived from registered state only
  // ---------------------------------------------------------------------
  always_comb begin
    w_target = 15'd0;
    if (!r_muted) begin
      w_target = 15'(r_vol * LVL_STEP);
    end
  end

  // ---------------------------------------------------------------------
  // One slew step toward the target. Direction comes from the current
  // target every time, so a target change mid-ramp just redirects it; a
  // remaining distance within one step lands exactly on the target.
  // ---------------------------------------------------------------------
  always_comb begin
    w_dir_up   = (w_target > r_amp);
    w_diff     = w_dir_up ? (w_target - r_amp) : (r_amp - w_target);
    w_amp_step = w_target;
    if (w_diff > STEP) begin
      w_amp_step = w_dir_up ? (r_amp + STEP) : (r_amp - STEP);
    end
  end

  assign w_tick = (r_cnt == CNT_LAST);

  // ---------------------------------------------------------------------
  // Ramp FSM, next state and datapath controls
  // IDLE holds the divider at 0, so the first step after a target change
  // lands a full RAMP_DIV cycles after RAMP is entered.
  // ---------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_amp_nxt   = r_amp;
    case (r_state)
      S_IDLE: begin
        if (r_amp != w_target) begin
          w_state_nxt = S_RAMP;
        end
      end
      S_RAMP: begin
        if (r_amp == w_target) begin
          // Target reached on an earlier tick: leave, divider clears.
          w_state_nxt = S_IDLE;
        end else if (w_tick) begin
          w_amp_nxt = w_amp_step;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // Datapath registers. Reset mid-ramp drops the amplitude to 0 at once.
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_up_prev <= 1'b1;
      r_dn_prev <= 1'b1;
      r_mt_prev <= 1'b1;
      r_vol     <= VINIT;
      r_muted   <= 1'b0;
      r_amp     <= 15'd0;
      r_cnt     <= '0;
    end else begin
      r_up_prev <= i_vol_up;
      r_dn_prev <= i_vol_down;
      r_mt_prev <= i_mute_tgl;
      r_vol     <= w_vol_nxt;
      r_muted   <= r_muted ^ w_mt_ev;
      r_amp     <= w_amp_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs. Busy is a decode of the state register, so it is registered;
  // the low sample is a pure negation of the high sample.
  // ---------------------------------------------------------------------
  assign o_vol_level = r_vol;
  assign o_muted     = r_muted;
  assign o_amp_pos   = {1'b0, r_amp};
  assign o_amp_neg   = 16'd0 - o_amp_pos;
  assign o_ramp_busy = (r_state == S_RAMP);

endmodule

// File: tb/tb_volume_amp_ctrl.sv
module tb_volume_amp_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        up = 1'b0, dn = 1'b0, mt = 1'b0;
  logic [3:0]  vol;
  logic        muted, busy;
  logic [15:0] ap, an;
  logic [3:0]  vol2;
  logic        muted2, busy2;
  logic [15:0] ap2, an2;

  always #5 clk = ~clk;

  volume_amp_ctrl #(.VOL_MAX(15), .VOL_INIT(8), .LVL_STEP(2000),
                    .RAMP_STEP(500), .RAMP_DIV(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_vol_up(up), .i_vol_down(dn), .i_mute_tgl(mt),
    .o_vol_level(vol), .o_muted(muted), .o_amp_pos(ap), .o_amp_neg(an),
    .o_ramp_busy(busy));

  // Second instance whose target (2300) is not a multiple of the step.
  volume_amp_ctrl #(.VOL_MAX(14), .VOL_INIT(1), .LVL_STEP(2300),
                    .RAMP_STEP(500), .RAMP_DIV(4)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_vol_up(1'b0), .i_vol_down(1'b0), .i_mute_tgl(1'b0),
    .o_vol_level(vol2), .o_muted(muted2), .o_amp_pos(ap2), .o_amp_neg(an2),
    .o_ramp_busy(busy2));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_settle(input string nm, input int exp_amp, input int budget);
    int n;
    n = 0;
    while (!(int'(ap) == exp_amp && !busy) && n < budget) begin
      tick();
      n++;
    end
    chk({nm, " settled in budget"}, int'(n < budget), 1);
    chk({nm, " amp"}, int'(ap), exp_amp);
  endtask

  // Behavioural reference: arithmetic on levels and amplitude, with the
  // ramp timed by the number of cycles spent slewing.
  int m_vol, m_amp, m_n;
  bit m_muted, m_busy, m_pu, m_pd, m_pm;

  task automatic model_step(input bit r, input bit u, input bit d, input bit t);
    int tgt, nxt;
    bit ue, de, te;
    if (r) begin
      m_vol = 8; m_muted = 0; m_amp = 0; m_busy = 0; m_n = 0;
      m_pu = 1; m_pd = 1; m_pm = 1;
    end else begin
      ue = u && !m_pu; de = d && !m_pd; te = t && !m_pm;
      tgt = m_muted ? 0 : m_vol * 2000;
      nxt = m_amp;
      if (m_busy && (m_n % 4 == 3) && m_amp != tgt) begin
        if (tgt > m_amp) nxt = m_amp + ((tgt - m_amp < 500) ? tgt - m_amp : 500);
        else             nxt = m_amp - ((m_amp - tgt < 500) ? m_amp - tgt : 500);
      end
      m_n    = (m_busy && m_amp != tgt) ? m_n + 1 : 0;
      m_busy = (m_amp != tgt);
      m_amp  = nxt;
      if (ue && !de)      m_vol = (m_vol < 15) ? m_vol + 1 : 15;
      else if (de && !ue) m_vol = (m_vol > 0) ? m_vol - 1 : 0;
      if (te) m_muted = !m_muted;
      m_pu = u; m_pd = d; m_pm = t;
    end
  endtask

  typedef struct {
    bit r, u, d, t;
    int vol;
    bit mu;
    bit chk_amp;
  } vec_t;
  vec_t tbl[18];

  initial begin
    int prev, mx, n, bad;
    bit u, d, t;

    tbl[0]  = '{1, 0, 0, 0, 8, 0, 1};
    tbl[1]  = '{0, 0, 0, 0, 8, 0, 0};
    tbl[2]  = '{0, 1, 0, 0, 9, 0, 0};
    tbl[3]  = '{0, 1, 0, 0, 9, 0, 0};
    tbl[4]  = '{0, 0, 0, 0, 9, 0, 0};
    tbl[5]  = '{0, 0, 1, 0, 8, 0, 0};
    tbl[6]  = '{0, 0, 0, 0, 8, 0, 0};
    tbl[7]  = '{0, 1, 1, 0, 8, 0, 0};
    tbl[8]  = '{0, 0, 0, 0, 8, 0, 0};
    tbl[9]  = '{0, 0, 0, 1, 8, 1, 0};
    tbl[10] = '{0, 1, 0, 0, 9, 1, 0};
    tbl[11] = '{0, 0, 1, 1, 8, 0, 0};
    tbl[12] = '{0, 0, 0, 0, 8, 0, 0};
    tbl[13] = '{1, 1, 0, 0, 8, 0, 1};
    tbl[14] = '{0, 1, 0, 0, 8, 0, 0};
    tbl[15] = '{0, 0, 0, 0, 8, 0, 0};
    tbl[16] = '{0, 1, 0, 0, 9, 0, 0};
    tbl[17] = '{0, 1, 0, 1, 9, 1, 0};

    // ---- reset state ----
    tick(); tick();
    chk("reset vol", int'(vol), 8);
    chk("reset muted", int'(muted), 0);
    chk("reset amp_pos", int'(ap), 0);
    chk("reset amp_neg", int'($signed(an)), 0);
    chk("reset busy", int'(busy), 0);

    // ---- power-up ramp 0 -> 16000, and 0 -> 2300 on the second instance ----
    rst = 1'b0;
    tick();
    chk("ramp entry busy", int'(busy), 1);
    chk("ramp entry amp", int'(ap), 0);
    for (int s = 1; s <= 32; s++) begin
      repeat (4) tick();
      chk($sformatf("ramp step %0d amp", s), int'(ap), 500 * s);
      chk($sformatf("ramp step %0d busy", s), int'(busy), 1);
      if (s <= 5) chk($sformatf("odd ramp step %0d", s), int'(ap2), (s < 5) ? 500 * s : 2300);
      if (s == 6) begin
        chk("odd ramp final amp", int'(ap2), 2300);
        chk("odd ramp busy cleared", int'(busy2), 0);
      end
    end
    tick();
    chk("ramp done busy", int'(busy), 0);
    chk("ramp done amp_neg", int'($signed(an)), -16000);

    // ---- up and down rise together ----
    up = 1; dn = 1; tick();
    chk("up+down vol", int'(vol), 8);
    tick();
    chk("up+down stays idle", int'(busy), 0);
    up = 0; dn = 0; tick();

    // ---- mute down-ramp, reversed mid-way ----
    mt = 1; tick(); mt = 0;
    chk("mute on", int'(muted), 1);
    prev = 16000; bad = 0; n = 0;
    while (int'(ap) != 9000 && n < 400) begin
      tick(); n++;
      if (int'(ap) > prev || prev - int'(ap) > 500) bad++;
      prev = int'(ap);
    end
    chk("mute ramp reached 9000", int'(n < 400), 1);
    chk("mute ramp step errors", bad, 0);
    mt = 1; tick(); mt = 0;
    chk("mute off", int'(muted), 0);
    mx = int'(ap); n = 0;
    while (!(int'(ap) == 16000 && !busy) && n < 400) begin
      tick(); n++;
      if (int'(ap) > mx) mx = int'(ap);
    end
    chk("reverse ramp in budget", int'(n < 400), 1);
    chk("reverse ramp peak", mx, 16000);
    chk("reverse ramp final", int'(ap), 16000);

    // ---- hold then repeated presses, saturation ----
    up = 1; repeat (20) tick();
    chk("held up single event", int'(vol), 9);
    up = 0; tick();
    repeat (8) begin up = 1; tick(); up = 0; tick(); end
    chk("vol saturates", int'(vol), 15);
    wait_settle("saturated", 30000, 1000);

    // ---- reset mid-ramp with vol_up held ----
    dn = 1; tick(); dn = 0;
    repeat (6) tick();
    chk("mid ramp busy", int'(busy), 1);
    up = 1; rst = 1; tick(); rst = 0;
    chk("rst mid ramp vol", int'(vol), 8);
    chk("rst mid ramp amp", int'(ap), 0);
    chk("rst mid ramp busy", int'(busy), 0);
    repeat (5) tick();
    chk("held through rst no event", int'(vol), 8);
    up = 0; tick(); up = 1; tick();
    chk("re-press after rst", int'(vol), 9);
    up = 0;

    // ---- table-driven level / mute vectors ----
    for (int i = 0; i < 18; i++) begin
      rst = tbl[i].r; up = tbl[i].u; dn = tbl[i].d; mt = tbl[i].t;
      tick();
      chk($sformatf("tbl %0d vol", i), int'(vol), tbl[i].vol);
      chk($sformatf("tbl %0d muted", i), int'(muted), int'(tbl[i].mu));
      if (tbl[i].chk_amp) begin
        chk($sformatf("tbl %0d amp", i), int'(ap), 0);
        chk($sformatf("tbl %0d busy", i), int'(busy), 0);
      end
    end

    // ---- randomized run against the reference model ----
    u = 0; d = 0; t = 0;
    rst = 1; up = 0; dn = 0; mt = 0;
    model_step(1, 0, 0, 0);
    tick();
    rst = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0)  u = ~u;
      if ($urandom_range(0, 9) == 0)  d = ~d;
      if ($urandom_range(0, 39) == 0) t = ~t;
      up = u; dn = d; mt = t;
      model_step(0, u, d, t);
      tick();
      chk($sformatf("rand %0d vol", i), int'(vol), m_vol);
      chk($sformatf("rand %0d muted", i), int'(muted), int'(m_muted));
      chk($sformatf("rand %0d amp_pos", i), int'(ap), m_amp);
      chk($sformatf("rand %0d amp_neg", i), int'($signed(an)), -m_amp);
      chk($sformatf("rand %0d busy", i), int'(busy), int'(m_busy));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
